rs_syndrome: RTL and testbench



---
 rtl/rs_pkg.sv | 42 ++++
 rtl/rs_syndrome_gf_mul_const.sv | 19 +
 rtl/rs_syndrome.sv | 106 ++++++++++
 tb/tb_rs_syndrome.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rs_pkg: shared types, defaults and GF(2^8) helpers for the RS syndrome stage.
//   - N_DEF / T_DEF / GF_POLY_DEF : default code geometry and field polynomial
//   - symbol_t                    : one 8-bit field element
//   - gf_xtime / gf_mul           : multiply by x, general multiply (mod poly)
//   - alpha_pow                   : alpha^j, used to elaborate constant multipliers
package rs_pkg;

  localparam int         N_DEF       = 15;
  localparam int         T_DEF       = 2;
  localparam logic [8:0] GF_POLY_DEF = 9'h11D;

  typedef logic [7:0] symbol_t;

  // Multiply by x; poly_lo is the field polynomial without its x^8 term.
  function automatic symbol_t gf_xtime(input symbol_t a, input symbol_t poly_lo);
    return {a[6:0], 1'b0} ^ (a[7] ? poly_lo : 8'h00);
  endfunction

  // Shift-and-add multiply. With one operand constant this folds to a
  // shallow XOR network.
  function automatic symbol_t gf_mul(input symbol_t a, input symbol_t b,
                                     input symbol_t poly_lo);
    symbol_t p;
    symbol_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa, poly_lo);
    end
    return p;
  endfunction

  // alpha = x (0x02) is primitive for 0x11D.
  function automatic symbol_t alpha_pow(input int j, input symbol_t poly_lo);
    symbol_t r;
    r = 8'h01;
    for (int k = 0; k < j; k++) r = gf_xtime(r, poly_lo);
    return r;
  endfunction

endpackage

// File: rtl/rs_syndrome_gf_mul_const.sv
// gf_mul_const: combinational multiply of an 8-bit field element by a
// constant fixed at elaboration time.
//   CONST - constant multiplier
//   POLY  - field polynomial, low 8 bits (x^8 implied)
//   a_i   - multiplicand
//   p_o   - a_i * CONST mod (x^8 + POLY)
module gf_mul_const
  import rs_pkg::*;
#(
  parameter symbol_t CONST = 8'h02,
  parameter symbol_t POLY  = 8'h1D
) (
  input  symbol_t a_i,
  output symbol_t p_o
);

  assign p_o = gf_mul(a_i, CONST, POLY);

endmodule

// File: rtl/rs_syndrome.sv
// rs_syndrome: evaluates the received polynomial at alpha^1..alpha^2T by
// Horner accumulation, one symbol per valid cycle, highest degree first.
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - in_data carries a received symbol
//   in_data   - received symbol
//   syn_valid - one-cycle pulse after the last symbol of a codeword
//   syn_out   - S_j in bits [8j-1:8j-8], j = 1..2T, held until next codeword
//   err_flag  - any syndrome nonzero, held with syn_out
//   busy      - codeword partially received
module rs_syndrome
  import rs_pkg::*;
#(
  parameter int         N       = N_DEF,
  parameter int         T       = T_DEF,
  parameter logic [8:0] GF_POLY = GF_POLY_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            syn_valid,
  output logic [16*T-1:0] syn_out,
  output logic            err_flag,
  output logic            busy
);

  localparam int             NSYN = 2 * T;
  localparam int             CW   = $clog2(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  logic [CW-1:0]     sym_cnt_q, sym_cnt_d;
  symbol_t           acc_q [NSYN];
  symbol_t           acc_d [NSYN];
  symbol_t           mul_w [NSYN];
  logic [8*NSYN-1:0] syn_q, syn_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;

  logic first_sym;
  logic last_sym;

  assign first_sym = (sym_cnt_q == '0);
  assign last_sym  = in_valid && (sym_cnt_q == LAST);

  // acc index k holds S_(k+1), so its multiplier is alpha^(k+1).
  for (genvar k = 0; k < NSYN; k++) begin : g_mul
    gf_mul_const #(
      .CONST(alpha_pow(k + 1, GF_POLY[7:0])),
      .POLY (GF_POLY[7:0])
    ) u_mul (
      .a_i(acc_q[k]),
      .p_o(mul_w[k])
    );
  end

  always_comb begin
    sym_cnt_d = sym_cnt_q;
    acc_d     = acc_q;
    syn_d     = syn_q;
    err_d     = err_q;
    valid_d   = 1'b0;

    if (in_valid) begin
      sym_cnt_d = (sym_cnt_q == LAST) ? '0 : sym_cnt_q + CW'(1);
      for (int k = 0; k < NSYN; k++) begin
        // Symbol 0 overwrites rather than accumulates, so no clear cycle is
        // needed between back-to-back codewords.
        acc_d[k] = first_sym ? in_data : (mul_w[k] ^ in_data);
      end
    end

    // Capture the post-update accumulators so the result leaves one cycle
    // after the final symbol instead of two.
    if (last_sym) begin
      err_d   = 1'b0;
      for (int k = 0; k < NSYN; k++) begin
        syn_d[8*k +: 8] = acc_d[k];
        err_d           = err_d | (|acc_d[k]);
      end
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt_q <= '0;
      for (int k = 0; k < NSYN; k++) acc_q[k] <= '0;
      syn_q     <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      sym_cnt_q <= sym_cnt_d;
      for (int k = 0; k < NSYN; k++) acc_q[k] <= acc_d[k];
      syn_q     <= syn_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
    end
  end

  assign syn_valid = valid_q;
  assign syn_out   = syn_q;
  assign err_flag  = err_q;
  assign busy      = ~first_sym;

endmodule

// File: tb/tb_rs_syndrome.sv
module tb_rs_syndrome;

  localparam int N = 15;
  localparam int T = 2;

  typedef logic [7:0] cw_t [15];
  typedef logic [7:0] msg_t [11];

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [7:0]      in_data = 8'h00;
  logic            syn_valid;
  logic [16*T-1:0] syn_out;
  logic            err_flag;
  logic            busy;

  rs_syndrome #(.N(N), .T(T), .GF_POLY(9'h11D)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .syn_valid(syn_valid),
    .syn_out  (syn_out),
    .err_flag (err_flag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc_cyc = 0;

  int          pulse_cyc [$];
  logic [31:0] pulse_syn [$];
  logic        pulse_err [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (syn_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_syn.push_back(syn_out);
      pulse_err.push_back(err_flag);
    end
  end

  // ---------------- reference arithmetic (independent of the DUT) ----------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1D) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] m_pow(input logic [7:0] a, input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = m_mul(r, a);
    return r;
  endfunction

  // Direct power-sum evaluation: S_j = sum cw[i] * (alpha^j)^(14-i).
  function automatic logic [31:0] m_syn(input cw_t cw);
    logic [31:0] res;
    logic [7:0]  aj;
    logic [7:0]  s;
    res = '0;
    for (int j = 1; j <= 4; j++) begin
      aj = m_pow(8'h02, j);
      s  = 8'h00;
      for (int i = 0; i < 15; i++) s = s ^ m_mul(cw[i], m_pow(aj, 14 - i));
      res[8*(j-1) +: 8] = s;
    end
    return res;
  endfunction

  // Systematic RS(15,11) encoder, g(x) = prod_{j=1..4} (x + alpha^j).
  function automatic cw_t m_encode(input msg_t msg);
    logic [7:0] g [5];
    logic [7:0] r [4];
    logic [7:0] fb;
    cw_t        cw;
    g[0] = 8'h01; g[1] = 8'h00; g[2] = 8'h00; g[3] = 8'h00; g[4] = 8'h00;
    for (int j = 1; j <= 4; j++) begin
      for (int k = 4; k >= 1; k--) g[k] = g[k-1] ^ m_mul(g[k], m_pow(8'h02, j));
      g[0] = m_mul(g[0], m_pow(8'h02, j));
    end
    for (int k = 0; k < 4; k++) r[k] = 8'h00;
    for (int i = 0; i < 11; i++) begin
      fb = msg[i] ^ r[3];
      for (int k = 3; k >= 1; k--) r[k] = r[k-1] ^ m_mul(fb, g[k]);
      r[0] = m_mul(fb, g[0]);
      cw[i] = msg[i];
    end
    cw[11] = r[3]; cw[12] = r[2]; cw[13] = r[1]; cw[14] = r[0];
    return cw;
  endfunction

  // ---------------- checking / driving helpers ------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_syms(input logic [7:0] q [$], input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = 8'hEE;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = q[i];
    end
    @(posedge clk);
    #1;
    last_acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic check_cw(input string tag, input int n0,
                          input logic [31:0] exp_syn, input logic exp_err);
    int          c;
    logic [31:0] s;
    logic        e;
    @(posedge clk);
    #1;
    chk({tag, "_npulse"}, 32'(pulse_cyc.size()), 32'(n0 + 1));
    c = -1; s = 'x; e = 1'bx;
    if (pulse_cyc.size() > n0) begin
      c = pulse_cyc[n0]; s = pulse_syn[n0]; e = pulse_err[n0];
    end
    chk({tag, "_latency"}, 32'(c), 32'(last_acc_cyc));
    chk({tag, "_syn"}, s, exp_syn);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    chk({tag, "_pulse_width"}, {31'b0, syn_valid}, 32'd0);
    chk({tag, "_busy_idle"}, {31'b0, busy}, 32'd0);
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    logic [7:0]  q [$];
    cw_t         cw;
    cw_t         cwf;
    cw_t         cw2;
    msg_t        msg;
    logic [31:0] exp;
    int          n0;

    repeat (3) @(negedge clk);
    chk("rst_syn_valid", {31'b0, syn_valid}, 32'd0);
    chk("rst_syn_out",   syn_out,            32'd0);
    chk("rst_err_flag",  {31'b0, err_flag},  32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // all-zero codeword
    q.delete();
    for (int i = 0; i < 15; i++) q.push_back(8'h00);
    n0 = pulse_cyc.size();
    send_syms(q, 1'b0);
    check_cw("zero", n0, 32'h0000_0000, 1'b0);

    // single 0x01 error at degree 0
    q.delete();
    for (int i = 0; i < 14; i++) q.push_back(8'h00);
    q.push_back(8'h01);
    n0 = pulse_cyc.size();
    send_syms(q, 1'b0);
    check_cw("deg0", n0, 32'h0101_0101, 1'b1);

    // single 0x01 error at degree 1 -> S_j = alpha^j
    q.delete();
    for (int i = 0; i < 15; i++) q.push_back((i == 13) ? 8'h01 : 8'h00);
    n0 = pulse_cyc.size();
    send_syms(q, 1'b0);
    check_cw("deg1", n0, 32'h1008_0402, 1'b1);

    // valid codeword for message 0x01..0x0B, with random gaps
    for (int i = 0; i < 11; i++) msg[i] = 8'(i + 1);
    cw = m_encode(msg);
    q.delete();
    for (int i = 0; i < 15; i++) q.push_back(cw[i]);
    n0 = pulse_cyc.size();
    send_syms(q, 1'b1);
    check_cw("valid_cw", n0, 32'h0000_0000, 1'b0);

    // same codeword with symbol 3 corrupted
    cwf = cw;
    cwf[3] = cwf[3] ^ 8'h5A;
    exp = m_syn(cwf);
    q.delete();
    for (int i = 0; i < 15; i++) q.push_back(cwf[i]);
    n0 = pulse_cyc.size();
    send_syms(q, 1'b1);
    check_cw("flip3", n0, exp, 1'b1);
    repeat (5) @(negedge clk);
    chk("flip3_hold_syn", syn_out, exp);
    chk("flip3_hold_err", {31'b0, err_flag}, 32'd1);

    // back-to-back: clean codeword then one with a single error
    cw2 = cw;
    cw2[7] = cw2[7] ^ 8'h21;
    exp = m_syn(cw2);
    q.delete();
    for (int i = 0; i < 15; i++) q.push_back(cw[i]);
    for (int i = 0; i < 15; i++) q.push_back(cw2[i]);
    n0 = pulse_cyc.size();
    send_syms(q, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b_npulse", 32'(pulse_cyc.size()), 32'(n0 + 2));
    if (pulse_cyc.size() >= n0 + 2) begin
      chk("b2b_spacing", 32'(pulse_cyc[n0+1] - pulse_cyc[n0]), 32'd15);
      chk("b2b_latency", 32'(pulse_cyc[n0+1]), 32'(last_acc_cyc));
      chk("b2b_syn0", pulse_syn[n0], 32'h0000_0000);
      chk("b2b_err0", {31'b0, pulse_err[n0]}, 32'd0);
      chk("b2b_syn1", pulse_syn[n0+1], exp);
      chk("b2b_err1", {31'b0, pulse_err[n0+1]}, 32'd1);
    end
    chk("b2b_final_syn", syn_out, exp);

    // reset after 7 symbols discards the partial codeword
    q.delete();
    for (int i = 0; i < 7; i++) q.push_back(8'h33);
    n0 = pulse_cyc.size();
    send_syms(q, 1'b0);
    chk("partial_busy", {31'b0, busy}, 32'd1);
    chk("partial_npulse", 32'(pulse_cyc.size()), 32'(n0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_syn_valid", {31'b0, syn_valid}, 32'd0);
    chk("midrst_syn_out",   syn_out,            32'd0);
    chk("midrst_err_flag",  {31'b0, err_flag},  32'd0);
    chk("midrst_busy",      {31'b0, busy},      32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 15; i++) q.push_back(8'h00);
    n0 = pulse_cyc.size();
    send_syms(q, 1'b0);
    check_cw("after_rst", n0, 32'h0000_0000, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
